adder_share_ctrl: RTL and testbench



---
 rtl/adder_share_ctrl.sv | 154 +++++++++++++++
 tb/tb_adder_share_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
// Shares one registered adder between NREQ requesters: arbitrate, latch operands, add, respond.
// Build option: define ADDER_SHARE_PRIO_EN for fixed-priority arbitration (default is round-robin).
module adder_share_ctrl #(
    parameter int  NREQ  = 4,
    parameter int  WIDTH = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_sum,
    output logic                  busy,
    output logic [7:0]            done_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        RESP
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q, a_d, b_d;
    logic [IDW-1:0]     id_q;
    logic               rsp_valid_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [2*WIDTH-1:0] rsp_sum_q;
    logic               busy_q;
    logic [7:0]         done_cnt_q;

    logic               grant_open;
    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic               xfer;

    // Grants are only offered when the adder is free or the pending result leaves this cycle.
    assign grant_open = !rst && ((state_q == IDLE) || (state_q == RESP && rsp_ready));

`ifdef ADDER_SHARE_PRIO_EN
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req_valid[i]) begin
                win_found = 1'b1;
                win_id    = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] ptr_q, ptr_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            automatic int idx = (int'(ptr_q) + k) % NREQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    assign ptr_d = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (xfer) begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign xfer = grant_open && win_found;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign a_d = req_a[win_id*WIDTH +: WIDTH];
    assign b_d = req_b[win_id*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            busy_q      <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        id_q    <= win_id;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    rsp_sum_q   <= (2*WIDTH)'({1'b0, a_q} + {1'b0, b_q});
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        done_cnt_q  <= done_cnt_q + 8'd1;
                        rsp_valid_q <= 1'b0;
                        if (xfer) begin
                            a_q     <= a_d;
                            b_q     <= b_d;
                            id_q    <= win_id;
                            state_q <= ADD;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = busy_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_adder_share_ctrl;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_sum;
    logic                  busy;
    logic [7:0]            done_cnt;

    int checks = 0;
    int errors = 0;

    // Model: a transaction being added (cook) and a result waiting for the consumer (pend).
    int m_ptr, m_cid, m_ca, m_cb, m_pid, m_psum, m_done;
    bit m_cook, m_pend;
    logic [NREQ-1:0] grants[$];

    always #5 clk = ~clk;

    adder_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .busy     (busy),
        .done_cnt (done_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cook = 0; m_pend = 0; m_pid = 0; m_psum = 0; m_done = 0;
        m_cid = 0; m_ca = 0; m_cb = 0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge, return 1 time unit later.
    task automatic cycle();
        bit              can;
        int              w;
        logic [NREQ-1:0] eg;
        @(negedge clk);
        can = !rst && ((!m_cook && !m_pend) || (m_pend && rsp_ready));
        w   = can ? pick(req_valid, m_ptr) : -1;
        eg  = '0;
        if (w >= 0) eg[w] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(eg));
        check("rsp_valid", 32'(rsp_valid), 32'(m_pend));
        if (m_pend) begin
            check("rsp_id", 32'(rsp_id), 32'(m_pid));
            check("rsp_sum", 32'(rsp_sum), 32'(m_psum));
        end
        check("busy", 32'(busy), 32'(m_cook || m_pend));
        check("done_cnt", 32'(done_cnt), 32'(m_done));
        if (req_ready != '0) grants.push_back(req_ready);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_pend && rsp_ready) begin
                m_done = (m_done + 1) % 256;
                m_pend = 0;
            end
            if (m_cook) begin
                m_pend = 1; m_pid = m_cid; m_psum = m_ca + m_cb; m_cook = 0;
            end
            if (w >= 0) begin
                m_cook = 1;
                m_cid  = w;
                m_ca   = int'(req_a[w*WIDTH +: WIDTH]);
                m_cb   = int'(req_b[w*WIDTH +: WIDTH]);
`ifndef ADDER_SHARE_PRIO_EN
                m_ptr  = (w + 1) % NREQ;
`endif
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        model_reset();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] order [6];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        model_reset();
        #1;
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_id", 32'(rsp_id), 32'(0));
        check("rst_rsp_sum", 32'(rsp_sum), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done_cnt", 32'(done_cnt), 32'(0));
        repeat (2) cycle();
        rst = 1'b0;

        // Single requester 0: 3 + 5.
        req_valid = 4'b0001; req_a = 16'h0003; req_b = 16'h0005; rsp_ready = 1'b1;
        cycle();
        req_valid = '0;
        cycle();
        check("t1_rsp_valid", 32'(rsp_valid), 32'(1));
        check("t1_rsp_sum", 32'(rsp_sum), 32'h08);
        check("t1_rsp_id", 32'(rsp_id), 32'(0));
        cycle();
        check("t1_done_cnt", 32'(done_cnt), 32'(1));

        // All requesters continuously valid.
        do_reset();
        grants.delete();
        req_valid = 4'hF; rsp_ready = 1'b1;
        repeat (12) begin
            cycle();
            req_a = (NREQ*WIDTH)'($urandom);
            req_b = (NREQ*WIDTH)'($urandom);
        end
`ifndef ADDER_SHARE_PRIO_EN
        check("t2_grant_count", 32'(grants.size()), 32'(6));
        for (int i = 0; i < 6 && i < grants.size(); i++) begin
            check($sformatf("t2_grant%0d", i), 32'(grants[i]), 32'(order[i]));
        end
`endif
        req_valid = '0;
        repeat (3) cycle();

        // Largest operands from requester 2.
        req_valid = 4'b0100; req_a = 16'h0F00; req_b = 16'h0F00;
        cycle();
        req_valid = '0;
        cycle();
        check("t3_rsp_sum", 32'(rsp_sum), 32'h1E);
        check("t3_rsp_id", 32'(rsp_id), 32'(2));
        cycle();

        // Back-pressure on the response channel while requests are pending.
        rsp_ready = 1'b0; req_valid = 4'hF; req_a = 16'h1234; req_b = 16'h4321;
        repeat (7) cycle();
        check("t4_hold_valid", 32'(rsp_valid), 32'(1));
        check("t4_hold_ready", 32'(req_ready), 32'(0));
        rsp_ready = 1'b1;
        cycle();
        req_valid = '0;
        repeat (3) cycle();

        // Reset while the adder is working.
        req_valid = 4'b0010; req_a = 16'h00A0; req_b = 16'h0050;
        cycle();
        req_valid = 4'hF;
        rst = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_rsp_valid", 32'(rsp_valid), 32'(0));
        check("t5_req_ready", 32'(req_ready), 32'(0));
        check("t5_done_cnt", 32'(done_cnt), 32'(0));
        check("t5_rsp_sum", 32'(rsp_sum), 32'(0));
        model_reset();
        cycle();
        rst = 1'b0; req_valid = '0;
        repeat (2) cycle();
        req_valid = 4'hF;
        #1;
        check("t5_first_grant", 32'(req_ready), 32'(4'b0001));
        cycle();
        req_valid = '0;
        repeat (3) cycle();

`ifdef ADDER_SHARE_PRIO_EN
        grants.delete();
        req_valid = 4'b1001;
        repeat (10) cycle();
        foreach (grants[i]) check("prio_only0", 32'(grants[i]), 32'(4'b0001));
        req_valid = 4'b1000;
        repeat (3) cycle();
        check("prio_then3", 32'(grants[grants.size()-1]), 32'(4'b1000));
`endif

        // Random traffic with occasional back-pressure and resets.
        repeat (400) begin
            req_valid = NREQ'($urandom);
            req_a     = (NREQ*WIDTH)'($urandom);
            req_b     = (NREQ*WIDTH)'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
